pong_input_cond: RTL

Input conditioner for the Pong game's four player buttons; sits directly upstream of the game logic's `inp1`..`inp4` inputs. It takes raw, asynchronous, bouncing MKR header pin levels and performs three steps:
- synchronises them into the 120 MHz game clock domain;
- debounces each channel and emits press/release pulses;
- resolves them into one frame-stable paddle direction command per player, latched on the game's frame tick.

---
 rtl/pong_input_pkg.sv | 15 +
 rtl/btn_debounce.sv | 59 +++++
 rtl/pong_input_cond.sv | 46 ++++
 3 files changed

// File: rtl/pong_input_pkg.sv
// pong_input_pkg: shared types and constants for the Pong button conditioner.
package pong_input_pkg;
    typedef enum logic [1:0] {REL, REL_CHK, PRS, PRS_CHK} db_state_e;
    localparam int DB_CNT_W = 24;
    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP = 2'b01;
    localparam logic [1:0] DIR_DN = 2'b10;
    localparam int BTN_P1_UP = 0;
    localparam int BTN_P1_DN = 1;
    localparam int BTN_P2_UP = 2;
    localparam int BTN_P2_DN = 3;
    function automatic logic [1:0] resolve_dir(input logic up, input logic dn);
        return (up == dn) ? DIR_HOLD : up ? DIR_UP : DIR_DN;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel - two-flop synchroniser, debounce FSM and
// press/release pulses.
module btn_debounce
    import pong_input_pkg::*;
#(
    parameter int DB_CYCLES = 600000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pressed,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);
    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 2);
    logic [1:0] sync;
    logic s, done, press_nxt, release_nxt;
    db_state_e state, state_nxt;
    logic [DB_CNT_W-1:0] cnt, cnt_nxt;
    assign s = sync[1];
    assign done = cnt == CNT_LAST;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
            state <= REL;
            cnt <= '0;
            press_pulse <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync <= {sync[0], pressed};
            state <= state_nxt;
            cnt <= cnt_nxt;
            press_pulse <= press_nxt;
            release_pulse <= release_nxt;
        end
    end
    // Any bounce inside a check window drops back and restarts the count from zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt = '0;
        unique case (state)
            REL:     state_nxt = s ? REL_CHK : REL;
            REL_CHK: begin
                state_nxt = !s ? REL : done ? PRS : REL_CHK;
                cnt_nxt = (s && !done) ? cnt + 1'b1 : '0;
            end
            PRS:     state_nxt = s ? PRS : PRS_CHK;
            PRS_CHK: begin
                state_nxt = s ? PRS : done ? REL : PRS_CHK;
                cnt_nxt = (!s && !done) ? cnt + 1'b1 : '0;
            end
        endcase
    end
    always_comb begin
        level = (state == PRS) || (state == PRS_CHK);
        press_nxt = (state == REL_CHK) && s && done;
        release_nxt = (state == PRS_CHK) && !s && done;
    end
endmodule

// File: rtl/pong_input_cond.sv
// pong_input_cond: conditions the four raw player buttons into debounced levels,
// edge pulses and one frame-stable paddle direction per player.
module pong_input_cond
    import pong_input_pkg::*;
#(
    parameter int DB_CYCLES = 600000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       iCLK,
    input  logic       iRESETn,
    input  logic [3:0] iBTN_RAW,
    input  logic       iFRAME_TICK,
    output logic [3:0] oLEVEL,
    output logic [3:0] oPRESS,
    output logic [3:0] oRELEASE,
    output logic [1:0] oP1_DIR,
    output logic [1:0] oP2_DIR
);
    logic [3:0] pressed, seen, req;
    assign pressed = iBTN_RAW ^ {4{ACTIVE_LOW}};
    for (genvar i = 0; i < 4; i++) begin : g_ch
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk(iCLK),
            .rst_n(iRESETn),
            .pressed(pressed[i]),
            .level(oLEVEL[i]),
            .press_pulse(oPRESS[i]),
            .release_pulse(oRELEASE[i])
        );
    end
    // seen keeps short presses that were released before the frame tick.
    assign req = oLEVEL | seen;
    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            seen <= '0;
            oP1_DIR <= DIR_HOLD;
            oP2_DIR <= DIR_HOLD;
        end else if (iFRAME_TICK) begin
            seen <= '0;
            oP1_DIR <= resolve_dir(req[BTN_P1_UP], req[BTN_P1_DN]);
            oP2_DIR <= resolve_dir(req[BTN_P2_UP], req[BTN_P2_DN]);
        end else begin
            seen <= seen | oPRESS;
        end
    end
endmodule
